// File: rtl/rns_to_bin_conv.sv
`default_nettype none
// ============================================================================
//  Module   : rns_to_bin_conv
//  Purpose  : Sequential residue-to-binary converter using a mixed-radix digit
//             search, one candidate step per clock.
//  Revision : 1.0  initial release
// ============================================================================
module rns_to_bin_conv #(
  parameter int                       NUM_DOMAINS = 2,
  parameter logic [9*NUM_DOMAINS-1:0] MODULI      = {9'd129, 9'd256},
  parameter int                       OUT_WID     = 16
) (
  input  logic                       clk100,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [8*NUM_DOMAINS-1:0]   in_residues,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OUT_WID-1:0]         out_data,
  output logic                       out_err,
  output logic                       busy
);

  localparam int c_jw = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  function automatic logic [8:0] mod_at(input int i);
    return MODULI[9*i +: 9];
  endfunction

  function automatic logic [63:0] prod_upto(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < NUM_DOMAINS; i++)
      if (i < n) p = p * {55'd0, mod_at(i)};
    return p;
  endfunction

  function automatic logic [8:0] s_const(input int j, input int k);
    logic [63:0] s;
    s = 64'd1;
    for (int i = 0; i < NUM_DOMAINS; i++)
      if (i < j) s = (s * {55'd0, mod_at(i)}) % {55'd0, mod_at(k)};
    return s[8:0];
  endfunction

  function automatic bit params_ok();
    bit          ok;
    logic [63:0] a, b, tmp;
    ok = (NUM_DOMAINS >= 1) && (NUM_DOMAINS <= 8);
    for (int i = 0; i < NUM_DOMAINS; i++) begin
      if (mod_at(i) < 9'd2 || mod_at(i) > 9'd256) ok = 1'b0;
      for (int j = i + 1; j < NUM_DOMAINS; j++) begin
        a = {55'd0, mod_at(i)};
        b = {55'd0, mod_at(j)};
        for (int g = 0; g < 16; g++)
          if (b != 64'd0) begin
            tmp = a % b;
            a   = b;
            b   = tmp;
          end
        if (a != 64'd1) ok = 1'b0;
      end
    end
    if (OUT_WID < 64 && prod_upto(NUM_DOMAINS) > (64'd1 << OUT_WID)) ok = 1'b0;
    return ok;
  endfunction

  localparam bit c_params_ok = params_ok();

  if (!c_params_ok) begin : g_param_check
    $error("rns_to_bin_conv: illegal NUM_DOMAINS, MODULI or OUT_WID");
  end

  // Elaboration tables: P_j, m_k and S_{j,k} = P_j mod m_k
  logic [OUT_WID-1:0] c_p [NUM_DOMAINS];
  logic [8:0]         c_m [NUM_DOMAINS];
  logic [8:0]         c_s [NUM_DOMAINS][NUM_DOMAINS];

  for (genvar j = 0; j < NUM_DOMAINS; j++) begin : g_const
    assign c_m[j] = mod_at(j);
    assign c_p[j] = OUT_WID'(prod_upto(j));
    for (genvar k = 0; k < NUM_DOMAINS; k++) begin : g_s
      assign c_s[j][k] = s_const(j, k);
    end
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t              r_state, w_state_next;
  logic [7:0]          r_res [NUM_DOMAINS];
  logic [8:0]          r_t   [NUM_DOMAINS];
  logic [8:0]          w_t_next [NUM_DOMAINS];
  logic [OUT_WID-1:0]  r_x;
  logic [c_jw-1:0]     r_j;
  logic [8:0]          r_cnt;
  logic                r_err;
  logic                w_match, w_last, w_cnt_max;
  logic                w_accept, w_add, w_advance, w_err_set;

  assign w_match   = (r_t[r_j] == {1'b0, r_res[r_j]});
  assign w_last    = (r_j == c_jw'(NUM_DOMAINS - 1));
  assign w_cnt_max = (r_cnt == c_m[r_j] - 9'd1);

  // The sum stays below 2*m_k, so one conditional subtract reduces it
  for (genvar k = 0; k < NUM_DOMAINS; k++) begin : g_tnext
    logic [8:0] w_sum;
    assign w_sum       = r_t[k] + c_s[r_j][k];
    assign w_t_next[k] = (w_sum >= c_m[k]) ? w_sum - c_m[k] : w_sum;
  end

  always_ff @(posedge clk100 or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_add        = 1'b0;
    w_advance    = 1'b0;
    w_err_set    = 1'b0;
    case (r_state)
      ST_IDLE: if (in_valid) begin
        w_accept     = 1'b1;
        w_state_next = ST_SCAN;
      end
      ST_SCAN: begin
        if (w_match) begin
          if (w_last) w_state_next = ST_DONE;
          else        w_advance    = 1'b1;
        end else if (w_cnt_max) begin
          w_state_next = ST_DONE;
          w_err_set    = 1'b1;
        end else begin
          w_add = 1'b1;
        end
      end
      ST_DONE: if (out_ready) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
    if (flush) begin
      w_state_next = ST_IDLE;
      w_accept     = 1'b0;
      w_add        = 1'b0;
      w_advance    = 1'b0;
      w_err_set    = 1'b0;
    end
  end

  always_ff @(posedge clk100 or posedge reset) begin
    if (reset) begin
      r_x   <= '0;
      r_j   <= '0;
      r_cnt <= '0;
      r_err <= 1'b0;
      for (int k = 0; k < NUM_DOMAINS; k++) begin
        r_res[k] <= '0;
        r_t[k]   <= '0;
      end
    end else begin
      if (w_accept) begin
        r_x   <= '0;
        r_j   <= '0;
        r_cnt <= '0;
        r_err <= 1'b0;
        for (int k = 0; k < NUM_DOMAINS; k++) begin
          r_res[k] <= in_residues[8*k +: 8];
          r_t[k]   <= '0;
        end
      end
      if (w_add) begin
        r_x   <= r_x + c_p[r_j];
        r_cnt <= r_cnt + 9'd1;
        for (int k = 0; k < NUM_DOMAINS; k++) r_t[k] <= w_t_next[k];
      end
      if (w_advance) begin
        r_j   <= r_j + c_jw'(1);
        r_cnt <= '0;
      end
      if (w_err_set) r_err <= 1'b1;
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign busy      = (r_state == ST_SCAN);
  assign out_valid = (r_state == ST_DONE);
  assign out_data  = r_x;
  assign out_err   = r_err & (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_rns_to_bin_conv.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rns_to_bin_conv
//  Purpose  : Self-checking bench for rns_to_bin_conv (default and 3-domain).
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_rns_to_bin_conv;

  logic        clk100 = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [15:0] in_residues;
  logic        in_ready, out_valid, out_err, busy;
  logic [15:0] out_data;

  logic        flush3, in_valid3, out_ready3;
  logic [23:0] in_residues3;
  logic        in_ready3, out_valid3, out_err3, busy3;
  logic [9:0]  out_data3;

  always #5 clk100 = ~clk100;

  rns_to_bin_conv dut (
    .clk100(clk100), .reset(reset), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready), .in_residues(in_residues), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_err(out_err), .busy(busy)
  );

  rns_to_bin_conv #(
    .NUM_DOMAINS(3), .MODULI({9'd9, 9'd8, 9'd7}), .OUT_WID(10)
  ) dut3 (
    .clk100(clk100), .reset(reset), .flush(flush3), .in_valid(in_valid3),
    .in_ready(in_ready3), .in_residues(in_residues3), .out_valid(out_valid3),
    .out_ready(out_ready3), .out_data(out_data3), .out_err(out_err3), .busy(busy3)
  );

  typedef struct {
    logic [7:0]  r1;
    logic [7:0]  r0;
    logic [15:0] data;
    logic        err;
    int          lat;   // 0: latency not checked
  } vec_t;

  typedef struct {
    logic [15:0] data;
    logic        err;
  } exp_t;

  vec_t        tbl [9];
  exp_t        sb [$];
  int unsigned q3 [$];
  int          checks   = 0;
  int          failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] r1, input logic [7:0] r0,
                      input logic [15:0] xd, input logic xe, input bit push);
    @(negedge clk100);
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid    = 1'b1;
    in_residues = {r1, r0};
    @(posedge clk100);
    #1;
    in_valid    = 1'b0;
    in_residues = 16'hA5A5 ^ {r0, r1};
    chk("busy_after_accept", 32'(busy), 32'd1);
    if (push) sb.push_back('{data: xd, err: xe});
  endtask

  task automatic wait_out(output int n, input int limit);
    n = 0;
    while (!out_valid && n < limit) begin
      @(posedge clk100);
      #1;
      n++;
    end
    if (!out_valid) chk("out_valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic take(input string name, input bit handshake);
    exp_t e;
    if (sb.size() == 0) begin
      chk({name, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    chk({name, "_err"}, 32'(out_err), 32'(e.err));
    if (!e.err) chk({name, "_data"}, 32'(out_data), 32'(e.data));
    if (handshake) begin
      @(negedge clk100);
      out_ready = 1'b1;
      @(posedge clk100);
      #1;
      out_ready = 1'b0;
      chk({name, "_valid_drop"}, 32'(out_valid), 32'd0);
      chk({name, "_in_ready_back"}, 32'(in_ready), 32'd1);
    end
  endtask

  initial begin
    int n;
    bit seen;
    tbl[0] = '{8'd97,  8'd232, 16'd1000,  1'b0, 237};
    tbl[1] = '{8'd0,   8'd0,   16'd0,     1'b0, 2};
    tbl[2] = '{8'd128, 8'd255, 16'd33023, 1'b0, 385};
    tbl[3] = '{8'd200, 8'd5,   16'd0,     1'b1, 0};
    tbl[4] = '{8'd1,   8'd1,   16'd1,     1'b0, 3};
    tbl[5] = '{8'd127, 8'd0,   16'd256,   1'b0, 3};
    tbl[6] = '{8'd0,   8'd129, 16'd129,   1'b0, 131};
    tbl[7] = '{8'd98,  8'd136, 16'd5000,  1'b0, 157};
    tbl[8] = '{8'd129, 8'd0,   16'd0,     1'b1, 0};

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_residues = '0;
    flush3 = 1'b0; in_valid3 = 1'b0; out_ready3 = 1'b0; in_residues3 = '0;
    repeat (3) @(posedge clk100);
    #1 reset = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);

    for (int i = 0; i < 9; i++) begin
      send(tbl[i].r1, tbl[i].r0, tbl[i].data, tbl[i].err, 1'b1);
      wait_out(n, 600);
      if (out_valid) begin
        if (tbl[i].lat != 0) chk($sformatf("lat_vec%0d", i), 32'(n), 32'(tbl[i].lat));
        take($sformatf("vec%0d", i), 1'b1);
      end
    end

    // Backpressure: result held while out_ready stays low
    send(8'd97, 8'd232, 16'd1000, 1'b0, 1'b1);
    wait_out(n, 600);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk100);
      #1;
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_data", 32'(out_data), 32'd1000);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    take("hold", 1'b1);

    // Flush at E0+50 aborts the conversion
    send(8'd97, 8'd232, 16'd0, 1'b0, 1'b0);
    repeat (49) @(posedge clk100);
    @(negedge clk100) flush = 1'b1;
    @(posedge clk100);
    #1 flush = 1'b0;
    chk("flush_scan_in_ready", 32'(in_ready), 32'd1);
    chk("flush_scan_busy", 32'(busy), 32'd0);
    seen = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk100);
      #1;
      if (out_valid) seen = 1'b1;
    end
    chk("flush_no_output", 32'(seen), 32'd0);

    // Flush in IDLE blocks acceptance
    @(negedge clk100);
    flush = 1'b1; in_valid = 1'b1; in_residues = {8'd97, 8'd232};
    @(posedge clk100);
    #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_idle_in_ready", 32'(in_ready), 32'd1);
    chk("flush_idle_busy", 32'(busy), 32'd0);

    // Flush in DONE drops out_valid without a handshake
    send(8'd0, 8'd0, 16'd0, 1'b0, 1'b1);
    wait_out(n, 50);
    take("flush_done", 1'b0);
    @(negedge clk100) flush = 1'b1;
    @(posedge clk100);
    #1 flush = 1'b0;
    chk("flush_done_valid", 32'(out_valid), 32'd0);
    chk("flush_done_in_ready", 32'(in_ready), 32'd1);

    // Asynchronous reset mid-SCAN, then a clean rerun
    send(8'd97, 8'd232, 16'd0, 1'b0, 1'b0);
    repeat (49) @(posedge clk100);
    @(negedge clk100) reset = 1'b1;
    #2;
    chk("async_rst_in_ready", 32'(in_ready), 32'd1);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    #1 reset = 1'b0;
    send(8'd97, 8'd232, 16'd1000, 1'b0, 1'b1);
    wait_out(n, 600);
    if (out_valid) begin
      chk("rerun_lat", 32'(n), 32'd237);
      take("rerun", 1'b1);
    end

    // Three-domain instance, moduli 7/8/9
    for (int v = 0; v < 200; v++) begin
      int unsigned x, got;
      int          w;
      x = $urandom_range(503);
      @(negedge clk100);
      if (!in_ready3) chk("d3_in_ready", 32'(in_ready3), 32'd1);
      in_valid3    = 1'b1;
      in_residues3 = {8'(x % 9), 8'(x % 8), 8'(x % 7)};
      @(posedge clk100);
      #1 in_valid3 = 1'b0;
      q3.push_back(x);
      w = 0;
      while (!out_valid3 && w < 40) begin
        @(posedge clk100);
        #1;
        w++;
      end
      if (!out_valid3) chk("d3_timeout", 32'd0, 32'd1);
      else if (q3.size() != 0) begin
        got = q3.pop_front();
        chk("d3_data", 32'(out_data3), got);
        chk("d3_err", 32'(out_err3), 32'd0);
        @(negedge clk100) out_ready3 = 1'b1;
        @(posedge clk100);
        #1 out_ready3 = 1'b0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
